// File: rtl/mwave_pkg.sv
// rtl/mwave_pkg.sv - shared types, constants and helpers for the microwave controller
package mwave_pkg;

    localparam int BCD_W = 4;
    typedef logic [BCD_W-1:0] bcd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_COOK,
        ST_PAUSED,
        ST_DONE
    } state_t;

    localparam logic [3:0] PWR_MAX = 4'd10;

    // Segments a-g in bit6..bit0, active high.
    localparam logic [6:0] SEG7_TBL [10] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
        7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B
    };

    function automatic logic [3:0] clamp_power(input logic [3:0] p);
        if (p == 4'd0 || p > PWR_MAX)
            return PWR_MAX;
        return p;
    endfunction

    function automatic logic [6:0] seg7(input bcd_t d);
        if (d > 4'd9)
            return 7'h00;
        return SEG7_TBL[d];
    endfunction

endpackage

// File: rtl/microwave_ctrl_v2_if.sv
// rtl/microwave_ctrl_v2_if.sv - front-panel / display bus; MWAVE_SEG7_EN adds segment outputs
interface microwave_ctrl_v2_if;
    import mwave_pkg::*;

    logic       key_valid;
    logic [3:0] key_code;
    logic       start;
    logic       stop;
    logic       clear;
    logic       door_closed;
    logic [3:0] power_lvl;
    bcd_t       mins;
    bcd_t       sec_tens;
    bcd_t       sec_ones;
    logic       mag_on;
    logic       cooking;
    logic       beep;
`ifdef MWAVE_SEG7_EN
    logic [6:0] min_segs;
    logic [6:0] secs_tens_segs;
    logic [6:0] secs_ones_segs;
`endif

    modport master (
`ifdef MWAVE_SEG7_EN
        input  min_segs, secs_tens_segs, secs_ones_segs,
`endif
        output key_valid, key_code, start, stop, clear, door_closed, power_lvl,
        input  mins, sec_tens, sec_ones, mag_on, cooking, beep
    );

    modport slave (
`ifdef MWAVE_SEG7_EN
        output min_segs, secs_tens_segs, secs_ones_segs,
`endif
        input  key_valid, key_code, start, stop, clear, door_closed, power_lvl,
        output mins, sec_tens, sec_ones, mag_on, cooking, beep
    );

endinterface

// File: rtl/mwave_bcd_mmss.sv
// rtl/mwave_bcd_mmss.sv - M:SS BCD digit registers with key shift-in and countdown
module mwave_bcd_mmss
    import mwave_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic i_clear,
    input  logic i_shift,
    input  bcd_t i_key,
    input  logic i_dec,
    output bcd_t o_mins,
    output bcd_t o_tens,
    output bcd_t o_ones,
    output logic o_zero,
    output logic o_last
);

    bcd_t r_mins;
    bcd_t r_tens;
    bcd_t r_ones;

    // Tens may legally hold 6-9 after key entry; the borrow only reloads 5 when tens is 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mins <= '0;
            r_tens <= '0;
            r_ones <= '0;
        end else if (i_clear) begin
            r_mins <= '0;
            r_tens <= '0;
            r_ones <= '0;
        end else if (i_shift) begin
            r_mins <= r_tens;
            r_tens <= r_ones;
            r_ones <= i_key;
        end else if (i_dec) begin
            if (r_ones != 4'd0) begin
                r_ones <= r_ones - 4'd1;
            end else if (r_tens != 4'd0) begin
                r_tens <= r_tens - 4'd1;
                r_ones <= 4'd9;
            end else begin
                r_mins <= r_mins - 4'd1;
                r_tens <= 4'd5;
                r_ones <= 4'd9;
            end
        end
    end

    assign o_mins = r_mins;
    assign o_tens = r_tens;
    assign o_ones = r_ones;
    assign o_zero = (r_mins == 4'd0) && (r_tens == 4'd0) && (r_ones == 4'd0);
    assign o_last = (r_mins == 4'd0) && (r_tens == 4'd0) && (r_ones == 4'd1);

endmodule

// File: rtl/microwave_ctrl_v2.sv
// rtl/microwave_ctrl_v2.sv - microwave controller top: FSM, tick/duty counters; MWAVE_SEG7_EN adds 7-seg outputs
module microwave_ctrl_v2
    import mwave_pkg::*;
#(
    parameter int CLK_DIV    = 50000000,
    parameter int PWR_WINDOW = 10,
    parameter int BEEP_TICKS = 3
) (
    input  logic                 clk,
    input  logic                 resetn,
    microwave_ctrl_v2_if.slave   bus
);

    localparam int                TICK_W    = $clog2(CLK_DIV);
    localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(CLK_DIV - 1);
    localparam logic [7:0]        WIN_MAX   = 8'(PWR_WINDOW - 1);
    localparam logic [7:0]        BEEP_LAST = 8'(BEEP_TICKS - 1);

    state_t            r_state;
    state_t            w_next;
    logic [TICK_W-1:0] r_tick;
    logic [7:0]        r_win;
    logic [7:0]        r_beep_cnt;
    logic [3:0]        r_power;
    logic              r_cooking;
    logic              r_beep;

    logic w_tick, w_key_ok, w_clr, w_shift, w_dec, w_enter_cook, w_zero, w_last;
    bcd_t w_mins, w_tens, w_ones;

    assign w_tick   = (r_state == ST_COOK || r_state == ST_DONE) && (r_tick == TICK_MAX);
    assign w_key_ok = bus.key_valid && (bus.key_code <= 4'd9);

    mwave_bcd_mmss u_bcd (
        .clk     (clk),
        .resetn  (resetn),
        .i_clear (w_clr),
        .i_shift (w_shift),
        .i_key   (bus.key_code),
        .i_dec   (w_dec),
        .o_mins  (w_mins),
        .o_tens  (w_tens),
        .o_ones  (w_ones),
        .o_zero  (w_zero),
        .o_last  (w_last)
    );

    // Event priority: clear > stop > door-open > start > key.
    always_comb begin
        w_next       = r_state;
        w_clr        = 1'b0;
        w_shift      = 1'b0;
        w_dec        = 1'b0;
        w_enter_cook = 1'b0;
        if (bus.clear) begin
            w_next = ST_IDLE;
            w_clr  = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.stop) begin
                        w_clr = 1'b1;
                    end else if (w_key_ok) begin
                        w_shift = 1'b1;
                        w_next  = ST_ENTRY;
                    end
                end
                ST_ENTRY: begin
                    if (bus.stop) begin
                        w_next = ST_IDLE;
                        w_clr  = 1'b1;
                    end else if (bus.start && bus.door_closed && !w_zero) begin
                        w_enter_cook = 1'b1;
                        w_next       = ST_COOK;
                    end else if (w_key_ok) begin
                        w_shift = 1'b1;
                    end
                end
                ST_COOK: begin
                    if (bus.stop || !bus.door_closed) begin
                        w_next = ST_PAUSED;
                    end else if (w_tick) begin
                        w_dec = 1'b1;
                        if (w_last)
                            w_next = ST_DONE;
                    end
                end
                ST_PAUSED: begin
                    if (bus.stop) begin
                        w_next = ST_IDLE;
                        w_clr  = 1'b1;
                    end else if (bus.start && bus.door_closed) begin
                        w_enter_cook = 1'b1;
                        w_next       = ST_COOK;
                    end
                end
                ST_DONE: begin
                    if (bus.stop || (w_tick && r_beep_cnt == BEEP_LAST)) begin
                        w_next = ST_IDLE;
                        w_clr  = 1'b1;
                    end
                end
                default: begin
                    w_next = ST_IDLE;
                    w_clr  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tick     <= '0;
            r_win      <= '0;
            r_beep_cnt <= '0;
            r_power    <= PWR_MAX;
            r_cooking  <= 1'b0;
            r_beep     <= 1'b0;
        end else begin
            if (w_enter_cook || w_tick || !(r_state == ST_COOK || r_state == ST_DONE))
                r_tick <= '0;
            else
                r_tick <= r_tick + TICK_W'(1);

            if (w_enter_cook)
                r_win <= '0;
            else if (w_dec)
                r_win <= (r_win == WIN_MAX) ? 8'd0 : r_win + 8'd1;

            if (r_state != ST_DONE)
                r_beep_cnt <= '0;
            else if (w_tick)
                r_beep_cnt <= r_beep_cnt + 8'd1;

            if (w_enter_cook)
                r_power <= clamp_power(bus.power_lvl);

            r_cooking <= (w_next == ST_COOK);
            r_beep    <= (w_next == ST_DONE);
        end
    end

    // Door term is combinational so the magnetron drops in the same cycle the door opens.
    assign bus.mag_on   = (r_state == ST_COOK) && (r_win < {4'd0, r_power}) && bus.door_closed;
    assign bus.mins     = w_mins;
    assign bus.sec_tens = w_tens;
    assign bus.sec_ones = w_ones;
    assign bus.cooking  = r_cooking;
    assign bus.beep     = r_beep;

`ifdef MWAVE_SEG7_EN
    logic [6:0] r_min_segs;
    logic [6:0] r_tens_segs;
    logic [6:0] r_ones_segs;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_min_segs  <= '0;
            r_tens_segs <= '0;
            r_ones_segs <= '0;
        end else begin
            r_min_segs  <= seg7(w_mins);
            r_tens_segs <= seg7(w_tens);
            r_ones_segs <= seg7(w_ones);
        end
    end

    assign bus.min_segs       = r_min_segs;
    assign bus.secs_tens_segs = r_tens_segs;
    assign bus.secs_ones_segs = r_ones_segs;
`endif

endmodule

// File: tb/tb_microwave_ctrl_v2.sv
// tb/tb_microwave_ctrl_v2.sv - self-checking bench for microwave_ctrl_v2
module tb_microwave_ctrl_v2;

    localparam int CLK_DIV    = 4;
    localparam int PWR_WINDOW = 10;
    localparam int BEEP_TICKS = 3;

    localparam int M_IDLE  = 0;
    localparam int M_ENTRY = 1;
    localparam int M_COOK  = 2;
    localparam int M_PAUSE = 3;
    localparam int M_DONE  = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    microwave_ctrl_v2_if bus ();

    microwave_ctrl_v2 #(
        .CLK_DIV    (CLK_DIV),
        .PWR_WINDOW (PWR_WINDOW),
        .BEEP_TICKS (BEEP_TICKS)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic       kv;
        logic [3:0] kc;
        logic       st;
        logic       sp;
        logic       cl;
        logic       dr;
        logic [3:0] pw;
        int         t;
        logic       ec;
        logic       emg;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: time kept as a decimal number MSS (0..999).
    int m_mode, m_n, m_cyc, m_tk, m_bp, m_pw;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dut_time();
        return int'(bus.mins) * 100 + int'(bus.sec_tens) * 10 + int'(bus.sec_ones);
    endfunction

    function automatic int dut_outs();
        return dut_time() * 8 + int'(bus.cooking) * 4 + int'(bus.mag_on) * 2 + int'(bus.beep);
    endfunction

    function automatic int model_outs();
        int mag;
        mag = (m_mode == M_COOK && (m_tk % PWR_WINDOW) < m_pw && bus.door_closed) ? 1 : 0;
        return m_n * 8 + ((m_mode == M_COOK) ? 4 : 0) + mag * 2 + ((m_mode == M_DONE) ? 1 : 0);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_n = 0; m_cyc = 0; m_tk = 0; m_bp = 0; m_pw = 10;
    endtask

    task automatic model_step();
        bit kv, door, tick, enter;
        int nm, pl;
        kv    = bus.key_valid && (bus.key_code <= 4'd9);
        door  = bus.door_closed;
        tick  = (m_mode == M_COOK || m_mode == M_DONE) && (m_cyc % CLK_DIV == CLK_DIV - 1);
        nm    = m_mode;
        enter = 0;
        if (bus.clear) begin
            nm = M_IDLE; m_n = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (!bus.stop && kv) begin
                    m_n = (m_n * 10 + int'(bus.key_code)) % 1000; nm = M_ENTRY;
                end
                M_ENTRY: begin
                    if (bus.stop) begin nm = M_IDLE; m_n = 0; end
                    else if (bus.start && door && m_n != 0) enter = 1;
                    else if (kv) m_n = (m_n * 10 + int'(bus.key_code)) % 1000;
                end
                M_COOK: begin
                    if (bus.stop || !door) nm = M_PAUSE;
                    else if (tick) begin
                        m_n = (m_n % 100 == 0) ? m_n - 41 : m_n - 1;
                        m_tk++;
                        if (m_n == 0) begin nm = M_DONE; m_bp = 0; end
                    end
                end
                M_PAUSE: begin
                    if (bus.stop) begin nm = M_IDLE; m_n = 0; end
                    else if (bus.start && door) enter = 1;
                end
                default: begin
                    if (bus.stop) begin nm = M_IDLE; m_n = 0; end
                    else if (tick) begin
                        m_bp++;
                        if (m_bp == BEEP_TICKS) nm = M_IDLE;
                    end
                end
            endcase
        end
        if (enter) begin
            pl = int'(bus.power_lvl);
            nm = M_COOK; m_cyc = 0; m_tk = 0;
            m_pw = (pl == 0 || pl > 10) ? 10 : pl;
        end else if (m_mode == M_COOK || m_mode == M_DONE) begin
            m_cyc++;
        end else begin
            m_cyc = 0;
        end
        m_mode = nm;
    endtask

    task automatic cyc(input logic kv, input logic [3:0] kc, input logic st,
                       input logic sp, input logic cl);
        bus.key_valid = kv; bus.key_code = kc;
        bus.start = st; bus.stop = sp; bus.clear = cl;
        @(posedge clk);
        model_step();
        #1;
        chk("model", dut_outs(), model_outs());
        bus.key_valid = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0;
    endtask

    task automatic idle();             cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0); endtask
    task automatic key(input int k);   cyc(1'b1, 4'(k), 1'b0, 1'b0, 1'b0); endtask
    task automatic press_start();      cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0); endtask
    task automatic press_stop();       cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b0); endtask
    task automatic press_clear();      cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1); endtask

    task automatic run_until_time(input int t, input int limit, input string name);
        int n = 0;
        while (dut_time() != t && n < limit) begin idle(); n++; end
        chk(name, dut_time(), t);
    endtask

    function automatic vec_t mk(logic kv, logic [3:0] kc, logic st, logic sp, logic cl,
                                logic dr, logic [3:0] pw, int t, logic ec, logic emg);
        vec_t v;
        v.kv = kv; v.kc = kc; v.st = st; v.sp = sp; v.cl = cl;
        v.dr = dr; v.pw = pw; v.t = t; v.ec = ec; v.emg = emg;
        return v;
    endfunction

    initial begin
        vec_t tbl[14];
        int cnt, n;

        bus.key_valid = 1'b0; bus.key_code = 4'd0; bus.start = 1'b0; bus.stop = 1'b0;
        bus.clear = 1'b0; bus.door_closed = 1'b1; bus.power_lvl = 4'd10;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", dut_outs(), 0);
        @(negedge clk);
        resetn = 1'b1;

        // Entry, ignored keys, refused starts, same-cycle clear/stop/start.
        tbl[0]  = mk(0, 0,  0, 0, 1, 1, 10, 0,   0, 0);
        tbl[1]  = mk(1, 5,  0, 0, 0, 1, 10, 5,   0, 0);
        tbl[2]  = mk(1, 7,  0, 0, 0, 1, 10, 57,  0, 0);
        tbl[3]  = mk(1, 8,  0, 0, 0, 1, 10, 578, 0, 0);
        tbl[4]  = mk(1, 9,  0, 0, 0, 1, 10, 789, 0, 0);
        tbl[5]  = mk(1, 12, 0, 0, 0, 1, 10, 789, 0, 0);
        tbl[6]  = mk(0, 0,  0, 0, 1, 1, 10, 0,   0, 0);
        tbl[7]  = mk(0, 0,  1, 0, 0, 1, 10, 0,   0, 0);
        tbl[8]  = mk(1, 0,  0, 0, 0, 1, 10, 0,   0, 0);
        tbl[9]  = mk(0, 0,  1, 0, 0, 1, 10, 0,   0, 0);
        tbl[10] = mk(1, 2,  0, 0, 0, 1, 10, 2,   0, 0);
        tbl[11] = mk(0, 0,  1, 0, 0, 0, 10, 2,   0, 0);
        tbl[12] = mk(1, 7,  1, 0, 0, 1, 10, 2,   1, 1);
        tbl[13] = mk(0, 0,  1, 1, 1, 1, 10, 0,   0, 0);
        for (int i = 0; i < 14; i++) begin
            bus.door_closed = tbl[i].dr;
            bus.power_lvl   = tbl[i].pw;
            cyc(tbl[i].kv, tbl[i].kc, tbl[i].st, tbl[i].sp, tbl[i].cl);
            chk($sformatf("tbl%0d", i),
                dut_time() * 4 + int'(bus.cooking) * 2 + int'(bus.mag_on),
                tbl[i].t * 4 + int'(tbl[i].ec) * 2 + int'(tbl[i].emg));
        end
        bus.door_closed = 1'b1;
        bus.power_lvl   = 4'd10;

        // 1:30 countdown: first decrement exactly CLK_DIV cycles after start, then 1:00 -> 0:59.
        key(1); key(3); key(0);
        chk("entry_130", dut_time(), 130);
        press_start();
        chk("cook_started", int'(bus.cooking), 1);
        idle(); idle(); idle();
        chk("no_early_dec", dut_time(), 130);
        idle();
        chk("first_dec", dut_time(), 129);
        run_until_time(100, 200, "reach_100");
        repeat (CLK_DIV) idle();
        chk("borrow_059", dut_time(), 59);
        press_clear();

        // Duty cycle with power 3 over a 0:20 cook.
        key(2); key(0);
        bus.power_lvl = 4'd3;
        press_start();
        for (int c = 0; c < 80; c++) begin
            chk("duty3", int'(bus.mag_on), (((c / CLK_DIV) % PWR_WINDOW) < 3) ? 1 : 0);
            idle();
        end
        chk("done_beep", int'(bus.beep), 1);
        press_clear();
        chk("clear_beep", int'(bus.beep), 0);

        // Power 0 clamps to full duty.
        key(1); key(5);
        bus.power_lvl = 4'd0;
        press_start();
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            cnt += int'(bus.mag_on);
            idle();
        end
        chk("duty_full", cnt, 40);
        press_clear();
        bus.power_lvl = 4'd10;

        // Door opens at 0:15, resume, run out, beep phase.
        key(2); key(0);
        press_start();
        run_until_time(15, 100, "reach_015");
        bus.door_closed = 1'b0;
        #1;
        chk("door_mag_comb", int'(bus.mag_on), 0);
        idle();
        chk("paused_cook", int'(bus.cooking), 0);
        repeat (10) idle();
        chk("paused_hold", dut_time(), 15);
        bus.door_closed = 1'b1;
        press_start();
        chk("resumed", int'(bus.cooking), 1);
        n = 0;
        while (!bus.beep && n < 100) begin idle(); n++; end
        chk("beep_reached", int'(bus.beep), 1);
        chk("done_time", dut_time(), 0);
        cnt = 1; n = 0;
        idle();
        while (bus.beep && n < 40) begin cnt++; idle(); n++; end
        chk("beep_len", cnt, BEEP_TICKS * CLK_DIV);
        chk("after_beep", int'(bus.cooking) * 2 + int'(bus.beep), 0);

        // Stop pauses, second stop clears.
        key(4); key(5);
        press_start();
        repeat (6) idle();
        press_stop();
        chk("stop_pause", dut_time() * 2 + int'(bus.cooking), 44 * 2);
        press_stop();
        chk("stop_idle", dut_time() * 2 + int'(bus.cooking), 0);

        // Asynchronous reset mid-cook at 2:41.
        key(2); key(4); key(5);
        press_start();
        repeat (4 * CLK_DIV) idle();
        chk("at_241", dut_time(), 241);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_reset", dut_outs(), 0);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        idle();

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(49) == 0) bus.door_closed = ~bus.door_closed;
            bus.power_lvl = 4'($urandom_range(15));
            cyc($urandom_range(5) == 0, 4'($urandom_range(15)), $urandom_range(9) == 0,
                $urandom_range(79) == 0, $urandom_range(299) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
